// File: rtl/game_pkg.sv
// Shared round-controller types: FSM state, code digit type and digit width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        ENTRY,
        MOTOR
    } round_state_t;

endpackage

// File: rtl/code_round_ctrl_if.sv
// Bundle of generator, keypad and display/motor signals around the round controller.
// Latency: n/a (wiring only).
// Backpressure: none; every strobe is a single-cycle pulse that the consumer must take.
interface code_round_ctrl_if #(
    parameter int CODE_LEN = 4
);
    import game_pkg::*;

    // Random generator side
    logic                          rnd_valid;
    logic [7:0]                    rnd;
    logic [1:0]                    rnd_dir;
    logic [1:0]                    rnd_dur;

    // Game control and keypad
    logic                          start;
    logic                          key_valid;
    digit_t                        key;

    // Display / motor driver side
    logic [DIGIT_W*CODE_LEN-1:0]   code_out;
    logic                          code_show;
    logic                          busy;
    logic                          pass;
    logic                          fail;
    logic                          motor_en;
    logic [1:0]                    motor_dir;
    logic [7:0]                    score;

    modport master (
        output start, rnd_valid, rnd, rnd_dir, rnd_dur, key_valid, key,
        input  code_out, code_show, busy, pass, fail, motor_en, motor_dir, score
    );

    modport slave (
        input  start, rnd_valid, rnd, rnd_dir, rnd_dur, key_valid, key,
        output code_out, code_show, busy, pass, fail, motor_en, motor_dir, score
    );

endinterface

// File: rtl/motor_timer.sv
// Runs the motor for (dur+1)*DUR_UNIT cycles after a load pulse; done flags the last run cycle.
// Latency: motor_en rises the cycle after load and falls right after the final counted cycle.
// Backpressure: none; a load while running restarts the count.
module motor_timer #(
    parameter int DUR_UNIT = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [1:0] dur,
    output logic       motor_en,
    output logic       done
);

    // Counter must hold the longest run, 4*DUR_UNIT, without wrapping.
    localparam int CW = $clog2(4 * DUR_UNIT + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] load_val;

    // Down-counter starts at N-1 so that exactly N cycles are spent with motor_en high.
    assign load_val = CW'((32'(dur) + 32'd1) * 32'(DUR_UNIT) - 32'd1);
    assign done     = motor_en && (cnt == '0);

    // Load, count down, and drop the enable on the terminal count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            motor_en <= 1'b0;
        end else if (load) begin
            cnt      <= load_val;
            motor_en <= 1'b1;
        end else if (motor_en) begin
            if (cnt == '0) begin
                motor_en <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/code_round_ctrl.sv
// Game round controller: captures a random code, checks keypad entry, runs the motor on a pass.
// Latency: outputs registered; pass/fail one cycle after the deciding key. Optional ENTRY_TIMEOUT_EN.
// Backpressure: none; strobes not relevant to the current state are dropped.
module code_round_ctrl
    import game_pkg::*;
#(
    parameter int CODE_LEN = 4,
    parameter int DUR_UNIT = 25_000_000
`ifdef ENTRY_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1_000_000_000
`endif
) (
    input  logic               clk,
    input  logic               reset,
    code_round_ctrl_if.slave   bus
);

    localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam logic [IW-1:0] LAST = IW'(CODE_LEN - 1);

    round_state_t  state;
    logic [IW-1:0] idx;
    digit_t        digits [CODE_LEN];
    logic [1:0]    dir_q;
    logic [1:0]    dur_q;
    logic [7:0]    score_q;
    logic          pass_q;
    logic          fail_q;
    logic          busy_q;
    logic          show_q;

    logic          key_match;
    logic          last_hit;
    logic          mt_done;
    logic          mt_en;

    // Only the low nibble of the generator value is a digit.
    logic          unused_rnd_hi;
    assign unused_rnd_hi = ^bus.rnd[7:4];

    assign key_match = (bus.key == digits[idx]);
    assign last_hit  = (state == ENTRY) && bus.key_valid && key_match && (idx == LAST);

`ifdef ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;
    logic          to_hit;

    assign to_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Idle-entry counter: zero outside ENTRY and after every key, so only silent cycles accumulate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if ((state != ENTRY) || bus.key_valid) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end
`endif

    // Round FSM with the code buffer, latched motor parameters, score and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            idx     <= '0;
            dir_q   <= '0;
            dur_q   <= '0;
            score_q <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            busy_q  <= 1'b0;
            show_q  <= 1'b0;
            for (int i = 0; i < CODE_LEN; i++) begin
                digits[i] <= '0;
            end
        end else begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= CAPTURE;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        for (int i = 0; i < CODE_LEN; i++) begin
                            digits[i] <= '0;
                        end
                    end
                end
                CAPTURE: begin
                    if (bus.rnd_valid) begin
                        digits[idx] <= bus.rnd[DIGIT_W-1:0];
                        if (idx == LAST) begin
                            dir_q  <= bus.rnd_dir;
                            dur_q  <= bus.rnd_dur;
                            idx    <= '0;
                            state  <= ENTRY;
                            show_q <= 1'b1;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                ENTRY: begin
                    if (bus.key_valid) begin
                        if (!key_match) begin
                            fail_q <= 1'b1;
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            show_q <= 1'b0;
                        end else if (idx == LAST) begin
                            pass_q <= 1'b1;
                            state  <= MOTOR;
                            show_q <= 1'b0;
                            if (score_q != 8'hFF) begin
                                score_q <= score_q + 8'd1;
                            end
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
`ifdef ENTRY_TIMEOUT_EN
                    else if (to_hit) begin
                        fail_q <= 1'b1;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        show_q <= 1'b0;
                    end
`endif
                end
                MOTOR: begin
                    if (mt_done) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    show_q <= 1'b0;
                end
            endcase
        end
    end

    motor_timer #(
        .DUR_UNIT (DUR_UNIT)
    ) u_motor_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (last_hit),
        .dur      (dur_q),
        .motor_en (mt_en),
        .done     (mt_done)
    );

    for (genvar g = 0; g < CODE_LEN; g++) begin : g_code_out
        assign bus.code_out[g*DIGIT_W +: DIGIT_W] = digits[g];
    end

    assign bus.code_show = show_q;
    assign bus.busy      = busy_q;
    assign bus.pass      = pass_q;
    assign bus.fail      = fail_q;
    assign bus.motor_en  = mt_en;
    assign bus.motor_dir = dir_q;
    assign bus.score     = score_q;

endmodule
